cp0_reg: RTL and testbench
==========================

# cp0_reg

Coprocessor-0 register file: the consumer of the exception unit's resolved `exc_flag`/`exc_type`/`exc_baddr` result and the producer of its `EPC` and interrupt-pending inputs. Sits at the MEM/WB boundary. Holds `BadVAddr`, `Count`, `Compare`, `Status`, `Cause` and `EPC`. Commits exception and ERET state updates, serves MFC0/MTC0, runs the on-chip timer, and raises the interrupt request back to the exception unit.

## Interface
- No parameters; register numbers and `ExcT` codes come from `defines.v`.
- clk  in  1  core clock
- resetn  in  1  asynchronous, active-low reset
- we_i  in  1  MTC0 write enable
- waddr_i  in  5  MTC0 destination register number
- wdata_i  in  32  MTC0 data
- raddr_i  in  5  MFC0 source register number
- rdata_o  out  32  MFC0 data (combinational)
- exc_flag_i  in  1  exception/interrupt/ERET committed this cycle
- exc_type_i  in  `ExcT  resolved type from the exception unit
- exc_pc_i  in  32  PC of the faulting instruction
- exc_baddr_i  in  32  bad address for AdEL/AdES
- exc_bd_i  in  1  faulting instruction is in a branch delay slot
- hw_int_i  in  6  external hardware interrupt lines
- epc_o  out  32  current EPC register
- status_o  out  32  current Status register
- cause_o  out  32  current Cause register
- exc_intr_o  out  1  interrupt pending and enabled

## Operation
- Register numbers: BadVAddr=8, Count=9, Compare=11, Status=12, Cause=13, EPC=14.
  - Any other `raddr_i` reads 0; MTC0 to any other number is ignored.
- Status: bit22 BEV is hardwired 1. IM=[15:8], EXL=[1], IE=[0]. MTC0 writes only IM/EXL/IE; all other bits read 0.
- Cause: BD=[31], TI=[30], IP[7:2]=[15:10] (hardware), IP[1:0]=[9:8] (software), ExcCode=[6:2].
  - MTC0 writes only IP[1:0].
  - IP[6:2] is a register sampling `hw_int_i[4:0]` every cycle. IP[7] = registered `hw_int_i[5]` OR TI.
- EPC and Compare: MTC0 writes all 32 bits. BadVAddr is read-only.
- ExcCode mapping:
  - Intr→0x00, AdEL1/AdEL2→0x04, AdES→0x05, SysC→0x08, Bp→0x09, RI→0x0A, Ov→0x0C.
- Exception commit (`exc_flag_i`=1, type ≠ ERET):
  - Always write ExcCode.
  - If EXL was 0:
    - Write EPC = `exc_bd_i` ? `exc_pc_i`−4 : `exc_pc_i`.
    - Write BD = `exc_bd_i`.
  - If EXL was 1: leave EPC and BD unchanged.
  - Set EXL=1.
  - AdEL1/AdEL2/AdES additionally write BadVAddr = `exc_baddr_i`.
- ERET commit: clear EXL only. No other field changes.
- Any commit with `exc_flag_i`=1 discards a same-cycle MTC0, because the writing instruction is being flushed.
- Timer:
  - A 1-bit tick toggles every cycle. Count increments when tick=1, so Count advances once per 2 cycles and wraps 0xFFFFFFFF→0.
  - MTC0 Count overrides the increment in that cycle.
  - TI is set on the edge after Count==Compare is observed in the registered values.
  - MTC0 Compare clears TI. Clear wins over a same-cycle match.
- `exc_intr_o` = IE & ~EXL & |(Cause[15:8] & Status[15:8]), computed combinationally from registered state.
- `epc_o`, `status_o`, `cause_o` are the raw registers.
- No read bypass: `rdata_o` shows pre-write values in the write cycle.

## Timing
- Reset (async assert, sync-to-clk deassert handled upstream):
  - Status=0x0040_0000; Cause, EPC, BadVAddr, Count, Compare, tick, sampled IP = 0.
  - Resulting outputs: `exc_intr_o`=0, `rdata_o` for Status=0x0040_0000.
- Reset mid-operation clears everything immediately, including a pending TI.
- All register updates take effect on the rising `clk` edge following the request. Visible on `rdata_o`/outputs the next cycle.
- `hw_int_i` → `exc_intr_o`: 1-cycle latency, from the sampling register.
- Count==Compare → TI visible: 1 cycle. → `exc_intr_o`: same cycle as TI, provided IM7 and IE are set.
- MTC0 Status setting IE → `exc_intr_o` may assert the next cycle.
- Simultaneous events:
  - Exception + MTC0 → exception wins, MTC0 dropped.
  - MTC0 Count + tick → written value, no increment.
  - MTC0 Compare + match → TI=0.

## Test plan
- Reset release → Status reads 0x0040_0000; Cause/EPC/Count read 0; `exc_intr_o`=0.
- Exception with no delay slot: EXL=0, exc_type=Ov, pc=0xBFC0_0100, bd=0 → EPC=0xBFC0_0100, ExcCode=0x0C, EXL=1, BD=0. Then ERET → EXL=0, EPC unchanged.
- Nested exception: EXL=1, exc_type=AdEL1, pc=0x8000_0010, baddr=0x8000_0011, bd=1 → EPC and BD unchanged, ExcCode=0x04, BadVAddr=0x8000_0011.
- Delay-slot exception: EXL=0, AdES, pc=0x8000_0020, bd=1 → EPC=0x8000_001C, BD=1, ExcCode=0x05.
- Timer interrupt:
  - MTC0 Status=0x0000_8001, Compare=5, Count=0.
  - Count reaches 5 after 10 cycles → TI=1, `exc_intr_o`=1 the cycle after the match.
  - MTC0 Compare=100 → TI=0, `exc_intr_o`=0 next cycle.
- Hardware interrupt masking: IE=1, IM=0x04, `hw_int_i`=6'b000001 → `exc_intr_o`=1 one cycle later. Set EXL via an exception → `exc_intr_o`=0. Same-cycle MTC0 to EPC during that exception is dropped.

Source files
------------

// File: rtl/cp0_reg_if.sv
// cp0_pkg: exception type codes and CP0 register numbers shared by the
// register file and its environment.
//
// cp0_reg_if: groups the pipeline-facing CP0 signals.
//   master modport: MEM/WB pipeline and exception unit side
//     (drives MTC0/MFC0 requests, exception commits and interrupt lines).
//   slave  modport: the CP0 register file
//     (returns MFC0 data, EPC/Status/Cause and the interrupt request).
//
// Signal summary:
//   we_i, waddr_i, wdata_i   MTC0 write request (register number, data)
//   raddr_i, rdata_o         MFC0 read (combinational data)
//   exc_flag_i, exc_type_i   exception/ERET commit and its resolved type
//   exc_pc_i, exc_baddr_i    faulting PC and bad address
//   exc_bd_i                 faulting instruction sits in a delay slot
//   hw_int_i                 external hardware interrupt lines
//   epc_o, status_o, cause_o raw register contents
//   exc_intr_o               enabled interrupt pending
//
// Handshake: there is no valid/ready pair on this bus. Every request
// (we_i, exc_flag_i) is a single-cycle strobe that is always accepted on
// the rising clk edge where it is high; the register file never stalls.

package cp0_pkg;

  typedef enum logic [3:0] {
    EXC_INTR  = 4'd0,
    EXC_ADEL1 = 4'd1,
    EXC_ADEL2 = 4'd2,
    EXC_ADES  = 4'd3,
    EXC_SYSC  = 4'd4,
    EXC_BP    = 4'd5,
    EXC_RI    = 4'd6,
    EXC_OV    = 4'd7,
    EXC_ERET  = 4'd8
  } exc_t;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

endpackage

interface cp0_reg_if;
  import cp0_pkg::*;

  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr_i;
  logic [31:0] rdata_o;
  logic        exc_flag_i;
  exc_t        exc_type_i;
  logic [31:0] exc_pc_i;
  logic [31:0] exc_baddr_i;
  logic        exc_bd_i;
  logic [5:0]  hw_int_i;
  logic [31:0] epc_o;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic        exc_intr_o;

  modport master (
    output we_i, waddr_i, wdata_i, raddr_i,
    output exc_flag_i, exc_type_i, exc_pc_i, exc_baddr_i, exc_bd_i,
    output hw_int_i,
    input  rdata_o, epc_o, status_o, cause_o, exc_intr_o
  );

  modport slave (
    input  we_i, waddr_i, wdata_i, raddr_i,
    input  exc_flag_i, exc_type_i, exc_pc_i, exc_baddr_i, exc_bd_i,
    input  hw_int_i,
    output rdata_o, epc_o, status_o, cause_o, exc_intr_o
  );

endinterface

// File: rtl/cp0_reg.sv
// cp0_reg: coprocessor-0 register file at the MEM/WB boundary.
// Holds BadVAddr, Count, Compare, Status, Cause and EPC; commits exception
// and ERET state, serves MFC0/MTC0, runs the Count/Compare timer and
// raises the interrupt request back to the exception unit.
//
// Ports:
//   clk     core clock
//   resetn  asynchronous active-low reset
//   bus     cp0_reg_if.slave (see the interface file for the signal list)
//
// Register layout:
//   Status: BEV[22]=1 (hardwired), IM[15:8], EXL[1], IE[0]; rest read 0.
//   Cause : BD[31], TI[30], IP[7:2]=[15:10] (hardware), IP[1:0]=[9:8]
//           (software), ExcCode[6:2]; rest read 0.

module cp0_reg
  import cp0_pkg::*;
(
  input  logic      clk,
  input  logic      resetn,
  cp0_reg_if.slave  bus
);

  // ------------------------------------------------------------------
  // Architectural state
  // ------------------------------------------------------------------
  logic [31:0] badvaddr;
  logic [31:0] count;
  logic [31:0] compare;
  logic [31:0] epc;
  logic        tick;

  logic [7:0]  status_im;
  logic        status_exl;
  logic        status_ie;

  logic        cause_bd;
  logic        cause_ti;
  logic [5:0]  cause_ip_hw;   // registered copy of hw_int_i
  logic [1:0]  cause_ip_sw;
  logic [4:0]  cause_code;

  // ------------------------------------------------------------------
  // Request decode
  // ------------------------------------------------------------------
  logic exc_commit;
  logic eret_commit;
  logic exc_take;
  logic mtc0;
  logic wr_count;
  logic wr_compare;
  logic wr_status;
  logic wr_cause;
  logic wr_epc;
  logic bad_addr_exc;
  logic [4:0]  exc_code_next;
  logic [31:0] epc_next;

  assign exc_commit  = bus.exc_flag_i;
  assign eret_commit = exc_commit && (bus.exc_type_i == EXC_ERET);
  assign exc_take    = exc_commit && (bus.exc_type_i != EXC_ERET);

  // The instruction doing an MTC0 is flushed by any same-cycle commit.
  assign mtc0        = bus.we_i && !exc_commit;
  assign wr_count    = mtc0 && (bus.waddr_i == REG_COUNT);
  assign wr_compare  = mtc0 && (bus.waddr_i == REG_COMPARE);
  assign wr_status   = mtc0 && (bus.waddr_i == REG_STATUS);
  assign wr_cause    = mtc0 && (bus.waddr_i == REG_CAUSE);
  assign wr_epc      = mtc0 && (bus.waddr_i == REG_EPC);

  assign bad_addr_exc = (bus.exc_type_i == EXC_ADEL1) ||
                        (bus.exc_type_i == EXC_ADEL2) ||
                        (bus.exc_type_i == EXC_ADES);

  // A delay-slot fault restarts at the branch, one word earlier.
  assign epc_next = bus.exc_bd_i ? (bus.exc_pc_i - 32'd4) : bus.exc_pc_i;

  always_comb begin
    exc_code_next = 5'h00;
    case (bus.exc_type_i)
      EXC_INTR:  exc_code_next = 5'h00;
      EXC_ADEL1: exc_code_next = 5'h04;
      EXC_ADEL2: exc_code_next = 5'h04;
      EXC_ADES:  exc_code_next = 5'h05;
      EXC_SYSC:  exc_code_next = 5'h08;
      EXC_BP:    exc_code_next = 5'h09;
      EXC_RI:    exc_code_next = 5'h0A;
      EXC_OV:    exc_code_next = 5'h0C;
      default:   exc_code_next = 5'h00;
    endcase
  end

  // ------------------------------------------------------------------
  // Timer: Count advances on every other cycle; TI latches a registered
  // Count==Compare and is cleared only by writing Compare.
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tick     <= 1'b0;
      count    <= 32'd0;
      compare  <= 32'd0;
      cause_ti <= 1'b0;
    end else begin
      tick <= ~tick;
      if (wr_count) begin
        count <= bus.wdata_i;
      end else begin
        count <= count + {31'd0, tick};
      end
      if (wr_compare) begin
        compare <= bus.wdata_i;
      end
      // Clear has priority over a match seen in the same cycle.
      if (wr_compare) begin
        cause_ti <= 1'b0;
      end else if (count == compare) begin
        cause_ti <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Status
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      status_im  <= 8'd0;
      status_exl <= 1'b0;
      status_ie  <= 1'b0;
    end else if (exc_take) begin
      status_exl <= 1'b1;
    end else if (eret_commit) begin
      status_exl <= 1'b0;
    end else if (wr_status) begin
      status_im  <= bus.wdata_i[15:8];
      status_exl <= bus.wdata_i[1];
      status_ie  <= bus.wdata_i[0];
    end
  end

  // ------------------------------------------------------------------
  // Cause (except TI, which lives with the timer)
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cause_ip_hw <= 6'd0;
      cause_ip_sw <= 2'd0;
      cause_bd    <= 1'b0;
      cause_code  <= 5'd0;
    end else begin
      cause_ip_hw <= bus.hw_int_i;
      if (exc_take) begin
        cause_code <= exc_code_next;
        // A nested exception keeps the original BD/EPC context.
        if (!status_exl) begin
          cause_bd <= bus.exc_bd_i;
        end
      end else if (wr_cause) begin
        cause_ip_sw <= bus.wdata_i[9:8];
      end
    end
  end

  // ------------------------------------------------------------------
  // EPC and BadVAddr
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      epc <= 32'd0;
    end else if (exc_take) begin
      if (!status_exl) begin
        epc <= epc_next;
      end
    end else if (wr_epc) begin
      epc <= bus.wdata_i;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      badvaddr <= 32'd0;
    end else if (exc_take && bad_addr_exc) begin
      badvaddr <= bus.exc_baddr_i;
    end
  end

  // ------------------------------------------------------------------
  // Register views and outputs
  // ------------------------------------------------------------------
  logic [31:0] status_word;
  logic [31:0] cause_word;
  logic [7:0]  cause_ip;

  // IP7 is shared between hardware line 5 and the timer.
  assign cause_ip = {cause_ip_hw[5] | cause_ti, cause_ip_hw[4:0], cause_ip_sw};

  assign status_word = {9'd0, 1'b1, 6'd0, status_im, 6'd0, status_exl, status_ie};
  assign cause_word  = {cause_bd, cause_ti, 14'd0, cause_ip, 1'b0, cause_code, 2'b00};

  // MFC0 reads registered values only, so a write is visible next cycle.
  always_comb begin
    bus.rdata_o = 32'd0;
    case (bus.raddr_i)
      REG_BADVADDR: bus.rdata_o = badvaddr;
      REG_COUNT:    bus.rdata_o = count;
      REG_COMPARE:  bus.rdata_o = compare;
      REG_STATUS:   bus.rdata_o = status_word;
      REG_CAUSE:    bus.rdata_o = cause_word;
      REG_EPC:      bus.rdata_o = epc;
      default:      bus.rdata_o = 32'd0;
    endcase
  end

  assign bus.epc_o      = epc;
  assign bus.status_o   = status_word;
  assign bus.cause_o    = cause_word;
  assign bus.exc_intr_o = status_ie && !status_exl && (|(cause_ip & status_im));

endmodule

// File: tb/tb_cp0_reg.sv
module tb_cp0_reg;
  import cp0_pkg::*;

  // ------------------------------------------------------------------
  // Clock / reset
  // ------------------------------------------------------------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  cp0_reg_if bus();

  cp0_reg dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (total=%0d bad=%0d)", total, bad);
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------------
  // Stimulus records
  // ------------------------------------------------------------------
  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic        flag;
    exc_t        typ;
    logic [31:0] pc;
    logic [31:0] baddr;
    logic        bd;
    logic [5:0]  hw;
  } in_t;

  typedef struct {
    in_t         in;
    logic [31:0] exp_rdata;
    logic [31:0] exp_epc;
    logic [31:0] exp_cause;
    logic        exp_intr;
  } vec_t;

  function automatic in_t mk(input logic we, input logic [4:0] waddr,
                             input logic [31:0] wdata, input logic [4:0] raddr,
                             input logic flag, input exc_t typ,
                             input logic [31:0] pc, input logic [31:0] baddr,
                             input logic bd, input logic [5:0] hw);
    in_t v;
    v.we = we; v.waddr = waddr; v.wdata = wdata; v.raddr = raddr;
    v.flag = flag; v.typ = typ; v.pc = pc; v.baddr = baddr; v.bd = bd; v.hw = hw;
    return v;
  endfunction

  function automatic in_t mtc(input logic [4:0] waddr, input logic [31:0] wdata,
                              input logic [4:0] raddr, input logic [5:0] hw);
    return mk(1'b1, waddr, wdata, raddr, 1'b0, EXC_INTR, 32'd0, 32'd0, 1'b0, hw);
  endfunction

  function automatic in_t exc(input exc_t typ, input logic [31:0] pc,
                              input logic [31:0] baddr, input logic bd,
                              input logic [4:0] raddr, input logic [5:0] hw);
    return mk(1'b0, 5'd0, 32'd0, raddr, 1'b1, typ, pc, baddr, bd, hw);
  endfunction

  function automatic in_t idle(input logic [4:0] raddr, input logic [5:0] hw);
    return mk(1'b0, 5'd0, 32'd0, raddr, 1'b0, EXC_INTR, 32'd0, 32'd0, 1'b0, hw);
  endfunction

  // ------------------------------------------------------------------
  // Reference model: register contents held as plain fields, composed
  // into words with shifts when compared.
  // ------------------------------------------------------------------
  logic [31:0] m_badv, m_count, m_compare, m_epc;
  logic [7:0]  m_im;
  logic        m_exl, m_ie, m_bd, m_ti, m_tick;
  logic [5:0]  m_hw;
  logic [1:0]  m_sw;
  logic [4:0]  m_code;

  task automatic model_reset();
    m_badv = 0; m_count = 0; m_compare = 0; m_epc = 0;
    m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_tick = 0;
    m_hw = 0; m_sw = 0; m_code = 0;
  endtask

  function automatic logic [4:0] code_of(input exc_t t);
    case (t)
      EXC_ADEL1, EXC_ADEL2: return 5'h04;
      EXC_ADES:             return 5'h05;
      EXC_SYSC:             return 5'h08;
      EXC_BP:               return 5'h09;
      EXC_RI:               return 5'h0A;
      EXC_OV:               return 5'h0C;
      default:              return 5'h00;
    endcase
  endfunction

  function automatic logic [31:0] m_status();
    return 32'h0040_0000 + (32'(m_im) << 8) + (32'(m_exl) << 1) + 32'(m_ie);
  endfunction

  function automatic logic [7:0] m_ip();
    logic [7:0] ip;
    ip = 8'(m_sw) + (8'(m_hw[4:0]) << 2);
    if (m_hw[5] || m_ti) ip = ip + 8'h80;
    return ip;
  endfunction

  function automatic logic [31:0] m_cause();
    return (32'(m_bd) << 31) + (32'(m_ti) << 30) + (32'(m_ip()) << 8) + (32'(m_code) << 2);
  endfunction

  function automatic logic m_intr();
    return m_ie && !m_exl && ((m_ip() & m_im) != 8'd0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_badv;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status();
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_update(input in_t v);
    logic [31:0] old_count, old_compare;
    logic old_exl, old_tick, take, mt;
    old_count = m_count; old_compare = m_compare;
    old_exl = m_exl; old_tick = m_tick;
    take = v.flag && (v.typ != EXC_ERET);
    mt = v.we && !v.flag;

    m_tick = !old_tick;
    if (mt && v.waddr == 5'd9) m_count = v.wdata;
    else if (old_tick) m_count = old_count + 1;
    if (mt && v.waddr == 5'd11) m_ti = 0;
    else if (old_count == old_compare) m_ti = 1;
    m_hw = v.hw;

    if (take) begin
      m_code = code_of(v.typ);
      if (!old_exl) begin
        m_epc = v.bd ? v.pc - 4 : v.pc;
        m_bd = v.bd;
      end
      m_exl = 1;
      if (v.typ == EXC_ADEL1 || v.typ == EXC_ADEL2 || v.typ == EXC_ADES) m_badv = v.baddr;
    end else if (v.flag) begin
      m_exl = 0;
    end else if (mt) begin
      case (v.waddr)
        5'd11: m_compare = v.wdata;
        5'd12: begin m_im = v.wdata[15:8]; m_exl = v.wdata[1]; m_ie = v.wdata[0]; end
        5'd13: m_sw = v.wdata[9:8];
        5'd14: m_epc = v.wdata;
        default: ;
      endcase
    end
  endtask

  // ------------------------------------------------------------------
  // Scoreboard helpers
  // ------------------------------------------------------------------
  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk32("model_rdata",  bus.rdata_o,  m_read(bus.raddr_i));
    chk32("model_epc",    bus.epc_o,    m_epc);
    chk32("model_status", bus.status_o, m_status());
    chk32("model_cause",  bus.cause_o,  m_cause());
    chk1 ("model_intr",   bus.exc_intr_o, m_intr());
  endtask

  // ------------------------------------------------------------------
  // Driver: called at a falling edge; applies one cycle of inputs,
  // advances the model at the rising edge, and checks at the next fall.
  // ------------------------------------------------------------------
  task automatic step(input in_t v);
    bus.we_i = v.we; bus.waddr_i = v.waddr; bus.wdata_i = v.wdata;
    bus.raddr_i = v.raddr; bus.exc_flag_i = v.flag; bus.exc_type_i = v.typ;
    bus.exc_pc_i = v.pc; bus.exc_baddr_i = v.baddr; bus.exc_bd_i = v.bd;
    bus.hw_int_i = v.hw;
    @(posedge clk);
    model_update(v);
    @(negedge clk);
    check_model();
  endtask

  vec_t vecs[15];

  initial begin
    in_t v;
    int  steps;
    logic [4:0] regs [7];

    regs[0] = 5'd8; regs[1] = 5'd9; regs[2] = 5'd11; regs[3] = 5'd12;
    regs[4] = 5'd13; regs[5] = 5'd14; regs[6] = 5'd3;

    // Directed vectors: {inputs, expected rdata, epc, cause, intr}.
    vecs[0]  = '{mtc(5'd11, 32'd100, 5'd13, 6'd0), 32'h0, 32'h0, 32'h0, 1'b0};
    vecs[1]  = '{exc(EXC_OV, 32'hBFC0_0100, 32'h0, 1'b0, 5'd14, 6'd0),
                 32'hBFC0_0100, 32'hBFC0_0100, 32'h0000_0030, 1'b0};
    vecs[2]  = '{exc(EXC_ERET, 32'h0, 32'h0, 1'b0, 5'd12, 6'd0),
                 32'h0040_0000, 32'hBFC0_0100, 32'h0000_0030, 1'b0};
    vecs[3]  = '{mtc(5'd12, 32'h2, 5'd12, 6'd0),
                 32'h0040_0002, 32'hBFC0_0100, 32'h0000_0030, 1'b0};
    vecs[4]  = '{exc(EXC_ADEL1, 32'h8000_0010, 32'h8000_0011, 1'b1, 5'd8, 6'd0),
                 32'h8000_0011, 32'hBFC0_0100, 32'h0000_0010, 1'b0};
    vecs[5]  = '{exc(EXC_ERET, 32'h0, 32'h0, 1'b0, 5'd12, 6'd0),
                 32'h0040_0000, 32'hBFC0_0100, 32'h0000_0010, 1'b0};
    vecs[6]  = '{exc(EXC_ADES, 32'h8000_0020, 32'h8000_0021, 1'b1, 5'd14, 6'd0),
                 32'h8000_001C, 32'h8000_001C, 32'h8000_0014, 1'b0};
    vecs[7]  = '{exc(EXC_ERET, 32'h0, 32'h0, 1'b0, 5'd8, 6'd0),
                 32'h8000_0021, 32'h8000_001C, 32'h8000_0014, 1'b0};
    vecs[8]  = '{mtc(5'd12, 32'h0000_0401, 5'd12, 6'b000001),
                 32'h0040_0401, 32'h8000_001C, 32'h8000_0414, 1'b1};
    vecs[9]  = '{mk(1'b1, 5'd14, 32'h1234_5678, 5'd14, 1'b1, EXC_INTR,
                    32'h8000_0100, 32'h0, 1'b0, 6'b000001),
                 32'h8000_0100, 32'h8000_0100, 32'h0000_0400, 1'b0};
    vecs[10] = '{exc(EXC_ERET, 32'h0, 32'h0, 1'b0, 5'd13, 6'd0),
                 32'h0, 32'h8000_0100, 32'h0, 1'b0};
    vecs[11] = '{mtc(5'd13, 32'h0000_0300, 5'd13, 6'd0),
                 32'h0000_0300, 32'h8000_0100, 32'h0000_0300, 1'b0};
    vecs[12] = '{mtc(5'd12, 32'h0000_0101, 5'd12, 6'd0),
                 32'h0040_0101, 32'h8000_0100, 32'h0000_0300, 1'b1};
    vecs[13] = '{mtc(5'd7, 32'hFFFF_FFFF, 5'd7, 6'd0),
                 32'h0, 32'h8000_0100, 32'h0000_0300, 1'b1};
    vecs[14] = '{mtc(5'd13, 32'h0, 5'd13, 6'd0),
                 32'h0, 32'h8000_0100, 32'h0, 1'b0};

    // Reset state, checked while reset is held.
    v = idle(5'd12, 6'd0);
    bus.we_i = 0; bus.waddr_i = 0; bus.wdata_i = 0; bus.raddr_i = 5'd12;
    bus.exc_flag_i = 0; bus.exc_type_i = EXC_INTR; bus.exc_pc_i = 0;
    bus.exc_baddr_i = 0; bus.exc_bd_i = 0; bus.hw_int_i = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk32("reset_status_rd", bus.rdata_o, 32'h0040_0000);
    chk32("reset_cause", bus.cause_o, 32'h0);
    chk32("reset_epc", bus.epc_o, 32'h0);
    chk1 ("reset_intr", bus.exc_intr_o, 1'b0);
    bus.raddr_i = 5'd9;
    #1;
    chk32("reset_count_rd", bus.rdata_o, 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    // Table-driven directed cases.
    for (int i = 0; i < 15; i++) begin
      step(vecs[i].in);
      chk32($sformatf("vec%0d_rdata", i), bus.rdata_o, vecs[i].exp_rdata);
      chk32($sformatf("vec%0d_epc", i), bus.epc_o, vecs[i].exp_epc);
      chk32($sformatf("vec%0d_cause", i), bus.cause_o, vecs[i].exp_cause);
      chk1 ($sformatf("vec%0d_intr", i), bus.exc_intr_o, vecs[i].exp_intr);
    end

    // Timer interrupt sequence.
    step(mtc(5'd12, 32'h0000_8001, 5'd12, 6'd0));
    step(mtc(5'd11, 32'd5, 5'd11, 6'd0));
    step(mtc(5'd9, 32'd0, 5'd9, 6'd0));
    steps = 0;
    while (m_count != 32'd5 && steps < 30) begin
      step(idle(5'd9, 6'd0));
      steps++;
    end
    chk1("timer_reach_bound", steps < 30, 1'b1);
    chk32("timer_count5", bus.rdata_o, 32'd5);
    step(idle(5'd13, 6'd0));
    chk1("timer_ti_set", bus.cause_o[30], 1'b1);
    chk1("timer_intr_set", bus.exc_intr_o, 1'b1);
    step(mtc(5'd11, 32'd100, 5'd13, 6'd0));
    chk1("timer_ti_clear", bus.cause_o[30], 1'b0);
    chk1("timer_intr_clear", bus.exc_intr_o, 1'b0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      v = idle(5'(regs[$urandom_range(0, 6)]), 6'($urandom_range(0, 63)));
      if ($urandom_range(0, 1) == 1) begin
        v.we = 1'b1;
        v.waddr = regs[$urandom_range(0, 6)];
        v.wdata = $urandom;
        if (v.waddr == 5'd11) v.wdata = m_count + 32'($urandom_range(0, 6));
        if (v.waddr == 5'd9 && $urandom_range(0, 1) == 1) v.wdata = 32'hFFFF_FFFE;
      end
      if ($urandom_range(0, 7) == 0) begin
        v.flag = 1'b1;
        v.typ = exc_t'($urandom_range(0, 8));
        v.pc = {$urandom, 2'b00} >> 2 << 2;
        v.baddr = $urandom;
        v.bd = 1'($urandom_range(0, 1));
      end
      step(v);
    end

    // Reset mid-operation with TI pending.
    step(mtc(5'd11, 32'h60, 5'd13, 6'd0));
    step(mtc(5'd9, 32'h60, 5'd13, 6'd0));
    step(idle(5'd13, 6'd0));
    chk1("pre_reset_ti", bus.cause_o[30], 1'b1);
    bus.raddr_i = 5'd12;
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    chk32("midreset_cause", bus.cause_o, 32'h0);
    chk32("midreset_status", bus.rdata_o, 32'h0040_0000);
    chk32("midreset_epc", bus.epc_o, 32'h0);
    chk1 ("midreset_intr", bus.exc_intr_o, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    for (int n = 0; n < 6; n++) step(idle(5'd9, 6'd0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
